seg7_scanner: RTL
=================

SEG7_SCANNER -- requirements
Module: seg7_scanner

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: number of multiplexed digits.
REQ-002 SHALL have parameter GAP_CYCLES, default 4: anode-off clk cycles between digits (anti-ghosting).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port scan_clk  input  1  divided scan clock from the clock divider, asynchronous to clk, treated as data.
REQ-006 SHALL have port value  input  4*NUM_DIGITS  hex value; nibble i drives digit i (digit 0 = rightmost).
REQ-007 SHALL have port digit_en  input  NUM_DIGITS  per-digit enable; 0 = digit dark.
REQ-008 SHALL have port dp  input  NUM_DIGITS  per-digit decimal point request.
REQ-009 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-010 SHALL have port seg_out  output  8  active-low segments, bits 0..6 = a..g, bit 7 = dp.
REQ-011 SHALL have port an_out  output  NUM_DIGITS  active-low digit anodes.
REQ-012 SHALL have port frame_done  output  1  one-clk pulse when the last digit's drive slot ends.

Function
REQ-013 SHALL synchronize scan_clk through two flops, then detect a rising edge with a third register; scan_tick is asserted exactly 3 clk cycles after scan_clk rises and lasts 1 cycle.
REQ-014 SHALL implement states IDLE, GAP, DRIVE.
REQ-015 IDLE: an_out all ones, seg_out 8'hFF; first scan_tick -> GAP, with the digit index held at 0.
REQ-016 GAP: an_out all ones, seg_out 8'hFF for exactly GAP_CYCLES cycles, then -> DRIVE.
REQ-017 DRIVE: exactly one an_out bit is low (bit = index) when the digit is shown; on scan_tick -> GAP and increment the index.
REQ-018 Index SHALL wrap from NUM_DIGITS-1 to 0; frame_done SHALL pulse in the cycle DRIVE of digit NUM_DIGITS-1 exits to GAP.
REQ-019 scan_tick arriving while in GAP SHALL be ignored (no queuing, no index change).
REQ-020 value, digit_en, dp and blank_lz SHALL be captured into shadow registers on entry to DRIVE with index 0; mid-frame input changes SHALL NOT appear until the next frame.
REQ-021 Hex decode SHALL use standard patterns for 0-F (e.g. 0 -> a..f on, g off; active-low 7'b1000000).
REQ-022 A digit whose digit_en bit is 0 SHALL keep its anode high and seg_out 8'hFF for its whole slot, while its slot timing is still consumed.
REQ-023 Leading-zero blanking: with blank_lz=1, zero nibbles from digit NUM_DIGITS-1 downward SHALL be blanked (segments a..g off) until the first nonzero nibble; digit 0 SHALL never be blanked.
REQ-024 On a blanked digit, the dp segment SHALL still follow the dp bit, and its anode SHALL be low only when the dp bit is set.
REQ-025 seg_out and an_out SHALL be registered outputs that change only on clk edges, with no combinational path from inputs.

Reset
REQ-026 While rst=0: state IDLE, index 0, sync flops 0, shadows 0, an_out all ones, seg_out 8'hFF, frame_done 0.
REQ-027 Reset asserted mid-DRIVE SHALL darken all digits immediately (asynchronously); after release, the block SHALL restart from IDLE.

Structure
REQ-028 Package seg7_pkg SHALL hold the state enum, the 16-entry segment pattern constants, and the SEG_OFF = 8'hFF constant.
REQ-029 The combinational nibble-to-pattern decode SHALL be sub-module seg7_hex_decode, instantiated once on the selected nibble.

Verification
REQ-030 scan_clk rising at cycle T SHALL produce an internal tick at T+3; 10 scan edges with GAP_CYCLES=4 SHALL give anodes 0..7,0,1 in order, each preceded by exactly 4 all-off cycles.
REQ-031 value=32'h0000_00A5, blank_lz=1, dp=0 SHALL give digits 7..2 dark, digit 1 = 'A' (7'b0001000), and digit 0 = '5' (7'b0010010).
REQ-032 value=32'h1234_5678, digit_en=8'h0F SHALL light digits 0-3 with 8,7,6,5 and keep digits 4-7 with anode high and seg_out 8'hFF.
REQ-033 A change to value from 32'h0 to 32'hFFFF_FFFF while digit 3 is displayed SHALL keep digits 4-7 showing 0, with F appearing only after the next frame_done.
REQ-034 Two scan_clk edges 2 clk cycles apart during GAP SHALL give one index increment only.
REQ-035 rst low while digit 5 is displayed SHALL set an_out=8'hFF immediately; after release and the first tick, digit 0 SHALL follow the GAP.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the multiplexed seven-segment scanner.
//   - seg7_state_t : scanner FSM states
//   - SEG_OFF      : all eight segments (a..g, dp) dark, active-low
//   - SEG_BLANK    : segments a..g dark, active-low
//   - SEG_HEX_0..F : active-low a..g patterns for hex digits, bit 0 = a
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAP   = 2'd1,
    ST_DRIVE = 2'd2
  } seg7_state_t;

  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  //                                   gfedcba
  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble to active-low a..g pattern.
//   nibble : input  4  hex digit to show
//   seg    : output 7  active-low segments, bit 0 = a .. bit 6 = g
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pattern lookup from the shared constants
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0:    seg = SEG_HEX_0;
      4'h1:    seg = SEG_HEX_1;
      4'h2:    seg = SEG_HEX_2;
      4'h3:    seg = SEG_HEX_3;
      4'h4:    seg = SEG_HEX_4;
      4'h5:    seg = SEG_HEX_5;
      4'h6:    seg = SEG_HEX_6;
      4'h7:    seg = SEG_HEX_7;
      4'h8:    seg = SEG_HEX_8;
      4'h9:    seg = SEG_HEX_9;
      4'hA:    seg = SEG_HEX_A;
      4'hB:    seg = SEG_HEX_B;
      4'hC:    seg = SEG_HEX_C;
      4'hD:    seg = SEG_HEX_D;
      4'hE:    seg = SEG_HEX_E;
      4'hF:    seg = SEG_HEX_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scanner.sv
// seg7_scanner: time-multiplexed driver for NUM_DIGITS common-anode digits.
// Each rising edge of the (asynchronous) scan clock advances to the next
// digit; between digits all anodes are held off for GAP_CYCLES clk cycles
// to avoid ghosting. Display inputs are snapshotted once per frame.
//   clk        : input  1             system clock, rising edge
//   rst        : input  1             asynchronous active-low reset
//   scan_clk   : input  1             divided scan clock, synchronized here
//   value      : input  4*NUM_DIGITS  nibble i shown on digit i (0 = rightmost)
//   digit_en   : input  NUM_DIGITS    per-digit enable, 0 = dark
//   dp         : input  NUM_DIGITS    per-digit decimal point request
//   blank_lz   : input  1             leading-zero blanking enable
//   seg_out    : output 8             active-low segments, [6:0]=g..a, [7]=dp
//   an_out     : output NUM_DIGITS    active-low anodes
//   frame_done : output 1             pulse when the last digit's slot ends
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      scan_clk,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic                      blank_lz,
  output logic [7:0]                seg_out,
  output logic [NUM_DIGITS-1:0]     an_out,
  output logic                      frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(GAP_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] ONE_HOT_0 = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic                    sync1_r, sync2_r, sync3_r, tick_r;
  seg7_state_t             state_r, state_nxt_s;
  logic [IDX_W-1:0]        idx_r, idx_nxt_s;
  logic [CNT_W-1:0]        gap_cnt_r, gap_cnt_nxt_s;
  logic                    capture_s, frame_end_s;
  logic [4*NUM_DIGITS-1:0] val_sh_r;
  logic [NUM_DIGITS-1:0]   en_sh_r, dp_sh_r;
  logic                    blz_sh_r;
  logic [NUM_DIGITS-1:0]   lz_s;
  logic [3:0]              nib_s;
  logic                    en_sel_s, dp_sel_s, lz_sel_s;
  logic [6:0]              pat_s;
  logic [7:0]              seg_nxt_s, seg_r;
  logic [NUM_DIGITS-1:0]   an_nxt_s, an_r;
  logic                    frame_done_r;

  // Two-flop synchronizer, edge-detect history flop and registered tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
      tick_r  <= 1'b0;
    end else begin
      sync1_r <= scan_clk;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      tick_r  <= sync2_r & ~sync3_r;
    end
  end

  // Scanner FSM next-state; ticks landing in GAP fall through unused
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    gap_cnt_nxt_s = gap_cnt_r;
    capture_s     = 1'b0;
    frame_end_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_r) begin
          state_nxt_s   = ST_GAP;
          idx_nxt_s     = {IDX_W{1'b0}};
          gap_cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_nxt_s = ST_DRIVE;
          capture_s   = (idx_r == {IDX_W{1'b0}});
        end else begin
          gap_cnt_nxt_s = gap_cnt_r + CNT_W'(1);
        end
      end
      ST_DRIVE: begin
        if (tick_r) begin
          state_nxt_s   = ST_GAP;
          gap_cnt_nxt_s = {CNT_W{1'b0}};
          idx_nxt_s     = (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
          frame_end_s   = (idx_r == LAST_IDX);
        end else begin
          state_nxt_s   = ST_DRIVE;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        idx_nxt_s     = {IDX_W{1'b0}};
        gap_cnt_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // FSM state, digit index and gap counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      idx_r     <= {IDX_W{1'b0}};
      gap_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      idx_r     <= idx_nxt_s;
      gap_cnt_r <= gap_cnt_nxt_s;
    end
  end

  // Per-frame snapshot of the display inputs, taken as digit 0 starts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_sh_r <= {(4*NUM_DIGITS){1'b0}};
      en_sh_r  <= {NUM_DIGITS{1'b0}};
      dp_sh_r  <= {NUM_DIGITS{1'b0}};
      blz_sh_r <= 1'b0;
    end else if (capture_s) begin
      val_sh_r <= value;
      en_sh_r  <= digit_en;
      dp_sh_r  <= dp;
      blz_sh_r <= blank_lz;
    end else begin
      val_sh_r <= val_sh_r;
      en_sh_r  <= en_sh_r;
      dp_sh_r  <= dp_sh_r;
      blz_sh_r <= blz_sh_r;
    end
  end

  // Leading-zero mask: a digit is a leading zero if it and every digit
  // above it are zero; digit 0 always shows so "0" stays visible
  always_comb begin
    logic run_v;
    run_v = 1'b1;
    lz_s  = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_v   = run_v & (val_sh_r[i*4 +: 4] == 4'h0);
      lz_s[i] = run_v;
    end
    lz_s[0] = 1'b0;
  end

  // Select the current digit's snapshot fields
  always_comb begin
    nib_s    = 4'h0;
    en_sel_s = 1'b0;
    dp_sel_s = 1'b0;
    lz_sel_s = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib_s    = (idx_r == IDX_W'(i)) ? val_sh_r[i*4 +: 4] : nib_s;
      en_sel_s = (idx_r == IDX_W'(i)) ? en_sh_r[i]         : en_sel_s;
      dp_sel_s = (idx_r == IDX_W'(i)) ? dp_sh_r[i]         : dp_sel_s;
      lz_sel_s = (idx_r == IDX_W'(i)) ? lz_s[i]            : lz_sel_s;
    end
  end

  seg7_hex_decode u_hex_decode (
    .nibble (nib_s),
    .seg    (pat_s)
  );

  // Output pattern for the current slot; a blanked digit keeps its anode
  // on only to show a requested decimal point
  always_comb begin
    seg_nxt_s = SEG_OFF;
    an_nxt_s  = AN_OFF;
    if (state_r == ST_DRIVE && en_sel_s) begin
      if (blz_sh_r && lz_sel_s) begin
        seg_nxt_s = {~dp_sel_s, SEG_BLANK};
        an_nxt_s  = dp_sel_s ? ~(ONE_HOT_0 << idx_r) : AN_OFF;
      end else begin
        seg_nxt_s = {~dp_sel_s, pat_s};
        an_nxt_s  = ~(ONE_HOT_0 << idx_r);
      end
    end else begin
      seg_nxt_s = SEG_OFF;
      an_nxt_s  = AN_OFF;
    end
  end

  // Registered outputs; reset darkens the display without waiting for clk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_r        <= SEG_OFF;
      an_r         <= AN_OFF;
      frame_done_r <= 1'b0;
    end else begin
      seg_r        <= seg_nxt_s;
      an_r         <= an_nxt_s;
      frame_done_r <= frame_end_s;
    end
  end

  assign seg_out    = seg_r;
  assign an_out     = an_r;
  assign frame_done = frame_done_r;

endmodule
